// File: rtl/input_unit_bank_sched_if.sv
// Handshake bundle between the upstream/downstream flit ports and the two-bank scheduler.
interface input_unit_bank_sched_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] fifo_write_en;
    logic [1:0] fifo_read_en;
    logic       out_sel;
    logic       out_valid;
    logic       out_ready;
    logic       flush;
    logic       busy_flush;
    logic       err_overflow;
    logic       err_underflow;

    modport master (
        output in_valid, out_ready, flush,
        input  in_ready, fifo_write_en, fifo_read_en, out_sel, out_valid,
               busy_flush, err_overflow, err_underflow
    );

    modport slave (
        input  in_valid, out_ready, flush,
        output in_ready, fifo_write_en, fifo_read_en, out_sel, out_valid,
               busy_flush, err_overflow, err_underflow
    );
endinterface

// File: rtl/input_unit_bank_sched.sv
// Two-bank input scheduler: balances writes across banks and replays them in acceptance order.
// Optional sticky error flags are built only when ROUTER_BANK_SCHED_ERR_EN is defined.
//
// state    | meaning
// ST_RUN   | normal accept/deliver operation
// ST_FLUSH | discarding one buffered flit per cycle, no traffic accepted
module input_unit_bank_sched #(
    parameter int BANK_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input_unit_bank_sched_if.slave   bus
);
    localparam int ORDER_DEPTH = 2 * BANK_DEPTH;
    localparam int CNT_W       = $clog2(BANK_DEPTH) + 1;
    localparam int PTR_W       = $clog2(ORDER_DEPTH);
    localparam int QCNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BANK_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt0;
    logic [CNT_W-1:0]    r_cnt1;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [QCNT_W-1:0]   r_q_count;
    logic                r_order [ORDER_DEPTH];

    logic w_empty;
    logic w_head;
    logic w_out_valid;
    logic w_busy;
    logic w_pop;
    logic w_rd0;
    logic w_rd1;
    logic w_space0;
    logic w_space1;
    logic w_in_ready;
    logic w_wr;
    logic w_tgt;
    logic w_wr0;
    logic w_wr1;

    assign w_empty = (r_q_count == '0);
    assign w_head  = r_order[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_out_valid = ~w_empty;
                w_pop       = ~w_empty & bus.out_ready;
                if (bus.flush) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_busy = 1'b1;
                w_pop  = ~w_empty;
                if (r_q_count <= QCNT_W'(1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_rd0 = w_pop & ~w_head;
    assign w_rd1 = w_pop &  w_head;

    // A bank being popped this cycle frees a slot the same cycle, so a full queue can still accept.
    assign w_space0   = (r_cnt0 < DEPTH_C) | w_rd0;
    assign w_space1   = (r_cnt1 < DEPTH_C) | w_rd1;
    assign w_in_ready = (r_state == ST_RUN) & (w_space0 | w_space1);
    assign w_wr       = bus.in_valid & w_in_ready;

    // Prefer the emptier bank (ties to bank 0), fall back to the other one when the choice is full.
    assign w_tgt = (r_cnt1 < r_cnt0) ? w_space1 : ~w_space0;
    assign w_wr0 = w_wr & ~w_tgt;
    assign w_wr1 = w_wr &  w_tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_q_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt0    <= r_cnt0 + CNT_W'(w_wr0) - CNT_W'(w_rd0);
            r_cnt1    <= r_cnt1 + CNT_W'(w_wr1) - CNT_W'(w_rd1);
            r_q_count <= r_q_count + QCNT_W'(w_wr) - QCNT_W'(w_pop);
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Order storage needs no reset: entries are only observed while r_q_count covers them.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_order[r_wr_ptr] <= w_tgt;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.fifo_write_en = {w_wr1, w_wr0};
    assign bus.fifo_read_en  = {w_rd1, w_rd0};
    assign bus.out_sel       = ~w_empty & w_head;
    assign bus.out_valid     = w_out_valid;
    assign bus.busy_flush    = w_busy;

`ifdef ROUTER_BANK_SCHED_ERR_EN
    logic r_err_ovf;
    logic r_err_unf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if ((r_state == ST_RUN) && bus.in_valid && !(w_space0 || w_space1)) begin
                r_err_ovf <= 1'b1;
            end
            if (w_pop && w_empty) begin
                r_err_unf <= 1'b1;
            end
        end
    end

    assign bus.err_overflow  = r_err_ovf;
    assign bus.err_underflow = r_err_unf;
`else
    assign bus.err_overflow  = 1'b0;
    assign bus.err_underflow = 1'b0;
`endif

endmodule
